// File: rtl/bpred_pkg.sv
// Shared types for the branch predictor update path:
// queued update entries and the update scheduler states.
package bpred_pkg;

   localparam int BPRED_ADDR_W = 32;

   typedef struct packed {
      logic [BPRED_ADDR_W-1:0] pc;
      logic [BPRED_ADDR_W-1:0] target;
      logic                    taken;
      logic                    pred;
   } bpred_update_t;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      PEND  = 2'd1,
      FORCE = 2'd2
   } bpred_sched_state_t;

   function automatic bpred_update_t bpred_pack(
      input logic [BPRED_ADDR_W-1:0] pc,
      input logic [BPRED_ADDR_W-1:0] target,
      input logic                    taken,
      input logic                    pred
   );
      bpred_update_t e;
      e.pc     = pc;
      e.target = target;
      e.taken  = taken;
      e.pred   = pred;
      return e;
   endfunction

endpackage

// File: rtl/bpred_update_fifo.sv
// In-order queue of resolved branch updates waiting
// for the predictor table write port.
module bpred_update_fifo
   import bpred_pkg::*;
#(
   parameter int DEPTH = 4
) (
   input  logic                     CLK,
   input  logic                     nRST,
   input  logic                     push,
   input  logic                     pop,
   input  bpred_update_t            din,
   output bpred_update_t            head,
   output logic [$clog2(DEPTH):0]   count
);

   localparam int PW = $clog2(DEPTH);
   localparam int CW = PW + 1;

   bpred_update_t mem [DEPTH];
   logic [PW-1:0] wr_ptr;
   logic [PW-1:0] rd_ptr;

   // Power-of-two depth lets the pointers wrap by overflow.
   always_ff @(posedge CLK or negedge nRST) begin
      if (!nRST) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + PW'(1);
         if (pop)  rd_ptr <= rd_ptr + PW'(1);
         unique case ({push, pop})
            2'b10:   count <= count + CW'(1);
            2'b01:   count <= count - CW'(1);
            default: count <= count;
         endcase
      end
   end

   always_ff @(posedge CLK) begin
      if (push) mem[wr_ptr] <= din;
   end

   assign head = mem[rd_ptr];

endmodule

// File: rtl/bpred_update_scheduler.sv
// Schedules queued branch outcomes into the shared
// single-ported predictor table, with a starvation guard.
module bpred_update_scheduler
   import bpred_pkg::*;
#(
   parameter int DEPTH        = 4,
   parameter int STARVE_LIMIT = 8,
   parameter int ADDR_W       = 32
) (
   input  logic                    CLK,
   input  logic                    nRST,
   input  logic                    resolve_valid,
   output logic                    resolve_ready,
   input  logic [ADDR_W-1:0]       resolve_pc,
   input  logic [ADDR_W-1:0]       resolve_target,
   input  logic                    resolve_taken,
   input  logic                    resolve_pred,
   input  logic                    lookup_req,
   output logic                    lookup_grant,
   output logic                    tbl_wr_en,
   output logic [ADDR_W-1:0]       tbl_wr_pc,
   output logic [ADDR_W-1:0]       tbl_wr_target,
   output logic                    tbl_wr_taken,
   output logic                    update_predictor,
   output logic                    prediction,
   output logic                    branch_result,
   output logic [$clog2(DEPTH):0]  queue_count
);

   localparam int QW = $clog2(DEPTH) + 1;
   localparam int SW = $clog2(STARVE_LIMIT + 1);
   localparam logic [SW-1:0] S_LAST = SW'(STARVE_LIMIT - 1);
   localparam logic [SW-1:0] S_MAX  = {SW{1'b1}};

   bpred_sched_state_t state;
   logic [SW-1:0]      starve_cnt;
   bpred_update_t      head;
   bpred_update_t      din;
   logic               push;
   logic               force_wr;
   logic               last_out;

   assign din = bpred_pack(
      BPRED_ADDR_W'(resolve_pc),
      BPRED_ADDR_W'(resolve_target),
      resolve_taken,
      resolve_pred
   );

   assign resolve_ready = (queue_count != QW'(DEPTH));
   assign push          = resolve_valid & resolve_ready;

   assign force_wr      = (state == FORCE);
   assign lookup_grant  = lookup_req & ~force_wr;
   assign tbl_wr_en     = (queue_count != '0) &
                          (~lookup_req | force_wr);

   assign tbl_wr_pc     = ADDR_W'(head.pc);
   assign tbl_wr_target = ADDR_W'(head.target);
   assign tbl_wr_taken  = head.taken;

   // The write about to retire is the last entry unless one arrives.
   assign last_out = (queue_count == QW'(1)) & ~push;

   bpred_update_fifo #(
      .DEPTH (DEPTH)
   ) u_fifo (
      .CLK   (CLK),
      .nRST  (nRST),
      .push  (push),
      .pop   (tbl_wr_en),
      .din   (din),
      .head  (head),
      .count (queue_count)
   );

   always_ff @(posedge CLK or negedge nRST) begin
      if (!nRST) begin
         state      <= IDLE;
         starve_cnt <= '0;
      end else begin
         unique case (state)
            IDLE: begin
               starve_cnt <= '0;
               if (push) state <= PEND;
            end
            PEND: begin
               if (tbl_wr_en) begin
                  starve_cnt <= '0;
                  if (last_out) state <= IDLE;
               end else if (lookup_req) begin
                  if (starve_cnt != S_MAX)
                     starve_cnt <= starve_cnt + SW'(1);
                  if (starve_cnt == S_LAST)
                     state <= FORCE;
               end
            end
            FORCE: begin
               starve_cnt <= '0;
               state      <= last_out ? IDLE : PEND;
            end
            default: begin
               starve_cnt <= '0;
               state      <= IDLE;
            end
         endcase
      end
   end

   always_ff @(posedge CLK or negedge nRST) begin
      if (!nRST) begin
         update_predictor <= 1'b0;
         prediction       <= 1'b0;
         branch_result    <= 1'b0;
      end else begin
         update_predictor <= tbl_wr_en;
         prediction       <= tbl_wr_en & head.pred;
         branch_result    <= tbl_wr_en & head.taken;
      end
   end

endmodule

// File: tb/tb_bpred_update_scheduler.sv
// Randomized and directed checks of the update scheduler
// against a queue-based behavioural model.
module tb_bpred_update_scheduler;
   import bpred_pkg::*;

   localparam int DEPTH = 4;
   localparam int LIMIT = 8;

   logic        CLK = 1'b0;
   logic        nRST = 1'b0;
   logic        resolve_valid = 1'b0;
   logic        resolve_ready;
   logic [31:0] resolve_pc = '0;
   logic [31:0] resolve_target = '0;
   logic        resolve_taken = 1'b0;
   logic        resolve_pred = 1'b0;
   logic        lookup_req = 1'b0;
   logic        lookup_grant;
   logic        tbl_wr_en;
   logic [31:0] tbl_wr_pc;
   logic [31:0] tbl_wr_target;
   logic        tbl_wr_taken;
   logic        update_predictor;
   logic        prediction;
   logic        branch_result;
   logic [2:0]  queue_count;

   int total = 0;
   int bad = 0;

   bpred_update_t q[$];
   int   lost = 0;
   logic p_up = 1'b0;
   logic p_pred = 1'b0;
   logic p_res = 1'b0;
   logic xfer;

   bpred_update_scheduler #(
      .DEPTH(DEPTH), .STARVE_LIMIT(LIMIT), .ADDR_W(32)
   ) dut (
      .CLK(CLK), .nRST(nRST),
      .resolve_valid(resolve_valid),
      .resolve_ready(resolve_ready),
      .resolve_pc(resolve_pc),
      .resolve_target(resolve_target),
      .resolve_taken(resolve_taken),
      .resolve_pred(resolve_pred),
      .lookup_req(lookup_req),
      .lookup_grant(lookup_grant),
      .tbl_wr_en(tbl_wr_en),
      .tbl_wr_pc(tbl_wr_pc),
      .tbl_wr_target(tbl_wr_target),
      .tbl_wr_taken(tbl_wr_taken),
      .update_predictor(update_predictor),
      .prediction(prediction),
      .branch_result(branch_result),
      .queue_count(queue_count)
   );

   always #5 CLK = ~CLK;

   task automatic chk(input string n, input logic [63:0] a,
                      input logic [63:0] e);
      total++;
      if (a !== e) begin
         bad++;
         $display("FAIL %s act=%0h exp=%0h t=%0t", n, a, e, $time);
      end
   endtask

   // One cycle: drive at negedge, compare, then advance the model.
   task automatic step(input logic v, input logic [31:0] pc,
                       input logic [31:0] tg, input logic tk,
                       input logic pr, input logic lr);
      logic e_rdy, e_frc, e_gnt, e_wr;
      bpred_update_t e;
      @(negedge CLK);
      resolve_valid  = v;
      resolve_pc     = pc;
      resolve_target = tg;
      resolve_taken  = tk;
      resolve_pred   = pr;
      lookup_req     = lr;
      #1;
      e_rdy = (q.size() != DEPTH);
      e_frc = (lost >= LIMIT);
      e_gnt = lr & ~e_frc;
      e_wr  = (q.size() != 0) && (!lr || e_frc);
      chk("ready", resolve_ready, e_rdy);
      chk("grant", lookup_grant, e_gnt);
      chk("wr_en", tbl_wr_en, e_wr);
      chk("count", queue_count, q.size());
      chk("upd", update_predictor, p_up);
      chk("pred", prediction, p_pred);
      chk("res", branch_result, p_res);
      if (e_wr) begin
         chk("wr_pc", tbl_wr_pc, q[0].pc);
         chk("wr_tgt", tbl_wr_target, q[0].target);
         chk("wr_tk", tbl_wr_taken, q[0].taken);
      end
      p_up   = e_wr;
      p_pred = e_wr ? q[0].pred : 1'b0;
      p_res  = e_wr ? q[0].taken : 1'b0;
      xfer   = v & e_rdy;
      if (e_wr) begin
         void'(q.pop_front());
         lost = 0;
      end else if (q.size() != 0 && lr) begin
         lost++;
      end
      if (xfer) begin
         e.pc = pc; e.target = tg; e.taken = tk; e.pred = pr;
         q.push_back(e);
      end
   endtask

   task automatic do_reset();
      @(negedge CLK);
      resolve_valid = 1'b0;
      lookup_req    = 1'b0;
      nRST          = 1'b0;
      #1;
      chk("rst_ready", resolve_ready, 1);
      chk("rst_grant", lookup_grant, 0);
      chk("rst_wr", tbl_wr_en, 0);
      chk("rst_upd", update_predictor, 0);
      chk("rst_pred", prediction, 0);
      chk("rst_res", branch_result, 0);
      chk("rst_cnt", queue_count, 0);
      q.delete();
      lost = 0;
      p_up = 0; p_pred = 0; p_res = 0;
      @(negedge CLK);
      nRST = 1'b1;
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog t=%0t", $time);
      $fatal(1);
   end

   initial begin
      int k;
      int bias;
      logic [31:0] rp;
      do_reset();

      for (int i = 0; i < 20; i++) begin
         step(0, 0, 0, 0, 0, 1);
         chk("t1_grant", lookup_grant, 1);
         chk("t1_wr", tbl_wr_en, 0);
         chk("t1_upd", update_predictor, 0);
      end

      step(1, 32'h100, 32'h2000, 1, 0, 0);
      step(0, 0, 0, 0, 0, 0);
      chk("t2_wr", tbl_wr_en, 1);
      chk("t2_pc", tbl_wr_pc, 32'h100);
      step(0, 0, 0, 0, 0, 0);
      chk("t2_upd", update_predictor, 1);
      chk("t2_pred", prediction, 0);
      chk("t2_res", branch_result, 1);
      chk("t2_cnt", queue_count, 0);
      step(0, 0, 0, 0, 0, 1);
      chk("t2_idle", lookup_grant, 1);

      step(1, 32'h200, 32'h3000, 0, 1, 1);
      for (int i = 1; i <= 10; i++) begin
         step(0, 0, 0, 0, 0, 1);
         if (i == 9) begin
            chk("t3_fgrant", lookup_grant, 0);
            chk("t3_fwr", tbl_wr_en, 1);
         end else begin
            chk("t3_grant", lookup_grant, 1);
         end
      end

      k = 0;
      for (int i = 0; i < 4; i++) begin
         step(1, 32'h400 + k * 4, 32'h800 + k, k[0], ~k[0], 1);
         if (xfer) k++;
      end
      step(1, 32'h400 + k * 4, 32'h800 + k, k[0], ~k[0], 1);
      chk("t4_ready", resolve_ready, 0);
      chk("t4_cnt", queue_count, 4);
      if (xfer) k++;
      for (int i = 0; i < 40 && k < 5; i++) begin
         step(1, 32'h400 + k * 4, 32'h800 + k, k[0], ~k[0], 1);
         if (xfer) k++;
      end
      chk("t4_acc", k, 5);
      for (int i = 0; i < 6; i++) step(0, 0, 0, 0, 0, 0);
      chk("t4_empty", queue_count, 0);

      do_reset();
      step(1, 32'h500, 32'h1, 1, 1, 1);
      step(1, 32'h504, 32'h2, 0, 0, 1);
      for (int i = 0; i < 4; i++) begin
         step(1, 32'h508 + i * 4, 32'h3 + i, 1, 0, 0);
         chk("t5_cnt", queue_count, 2);
         chk("t5_wr", tbl_wr_en, 1);
      end

      do_reset();
      for (int i = 0; i < 3; i++)
         step(1, 32'h600 + i * 4, 32'h7, 1, 1, 1);
      step(0, 0, 0, 0, 0, 0);
      chk("t6_cnt", queue_count, 3);
      do_reset();
      for (int i = 0; i < 3; i++) begin
         step(0, 0, 0, 0, 0, 0);
         chk("t6_upd", update_predictor, 0);
      end

      bias = 2;
      for (int i = 0; i < 4000; i++) begin
         if (i % 250 == 0) bias = $urandom_range(0, 4);
         if ($urandom_range(0, 499) == 0) begin
            do_reset();
         end else begin
            rp = $urandom;
            step($urandom_range(0, 9) < 6, rp, $urandom,
                 rp[3], rp[7], $urandom_range(0, 4) < bias);
         end
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
